// File: rtl/clock_divider_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// clock_divider_pkg : shared types and helpers for the clock divider
// Revision 1.0
// ---------------------------------------------------------------------------
package clock_divider_pkg;

  localparam int unsigned DIVISOR_WIDTH      = 32;
  localparam int unsigned DEFAULT_DIVISOR_HZ = 100_000_000;

  typedef logic [DIVISOR_WIDTH-1:0] divisor_t;

  // Divisor giving a clock_out of `hz` from the board clock (clock_out runs at tick/2).
  function automatic divisor_t divisor_for_hz(input int unsigned hz);
    if (hz == 0) return '0;
    return divisor_t'(DEFAULT_DIVISOR_HZ / (2 * hz));
  endfunction

endpackage : clock_divider_pkg
`default_nettype wire

// File: rtl/clock_divider_channel.sv
`default_nettype none
// ---------------------------------------------------------------------------
// clock_divider_channel : one divider channel (divisor, counter, tick, square wave)
// Revision 1.0
// ---------------------------------------------------------------------------
module clock_divider_channel
  import clock_divider_pkg::*;
#(
  parameter int          WIDTH           = DIVISOR_WIDTH,
  parameter int unsigned DEFAULT_DIVISOR = 50_000_000
) (
  input  logic             clock_in,
  input  logic             reset_n,
  input  logic             i_enable,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_tick,
  output logic             o_clock_out
);

  logic [WIDTH-1:0] r_div;
  logic [WIDTH-1:0] r_count;
  logic             r_tick;
  logic             r_clock_out;
  logic [WIDTH-1:0] w_term;

  // A divisor of zero is treated as one, so the terminal count never underflows.
  assign w_term = (r_div == '0) ? '0 : (r_div - WIDTH'(1));

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      r_div       <= WIDTH'(DEFAULT_DIVISOR);
      r_count     <= '0;
      r_tick      <= 1'b0;
      r_clock_out <= 1'b0;
    end else if (i_load) begin
      r_div   <= i_divisor;
      r_count <= '0;
      r_tick  <= 1'b0;
    end else if (i_enable) begin
      if (r_count == w_term) begin
        r_count     <= '0;
        r_tick      <= 1'b1;
        r_clock_out <= ~r_clock_out;
      end else begin
        r_count <= r_count + WIDTH'(1);
        r_tick  <= 1'b0;
      end
    end else begin
      r_tick <= 1'b0;
    end
  end

  assign o_tick      = r_tick;
  assign o_clock_out = r_clock_out;

endmodule : clock_divider_channel
`default_nettype wire

// File: rtl/clock_divider.sv
`default_nettype none
// ---------------------------------------------------------------------------
// clock_divider : multi-channel programmable clock divider / tick generator
// Revision 1.0
// ---------------------------------------------------------------------------
module clock_divider
  import clock_divider_pkg::*;
#(
  parameter int          CHANNELS        = 2,
  parameter int          WIDTH           = DIVISOR_WIDTH,
  parameter int unsigned DEFAULT_DIVISOR = 50_000_000
) (
  input  logic                                           clock_in,
  input  logic                                           reset_n,
  input  logic [CHANNELS-1:0]                            enable,
  input  logic                                           write_enable,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] write_channel,
  input  logic [WIDTH-1:0]                               write_divisor,
  output logic [CHANNELS-1:0]                            tick,
  output logic [CHANNELS-1:0]                            clock_out
);

  localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [SEL_W:0] c_num_ch = (SEL_W + 1)'(CHANNELS);

  logic                w_write_ok;
  logic [CHANNELS-1:0] w_load;

  // Indices past the last channel exist when CHANNELS is not a power of two.
  assign w_write_ok = write_enable && ({1'b0, write_channel} < c_num_ch);

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    assign w_load[k] = w_write_ok && (write_channel == SEL_W'(k));

    clock_divider_channel #(
      .WIDTH           (WIDTH),
      .DEFAULT_DIVISOR (DEFAULT_DIVISOR)
    ) u_channel (
      .clock_in    (clock_in),
      .reset_n     (reset_n),
      .i_enable    (enable[k]),
      .i_load      (w_load[k]),
      .i_divisor   (write_divisor),
      .o_tick      (tick[k]),
      .o_clock_out (clock_out[k])
    );
  end

endmodule : clock_divider
`default_nettype wire

// File: tb/tb_clock_divider.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_clock_divider : directed, table-driven bench for clock_divider
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_clock_divider;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  enable = 2'b00;
  logic        write_enable = 1'b0;
  logic        write_channel = 1'b0;
  logic [31:0] write_divisor = '0;
  logic [1:0]  tick;
  logic [1:0]  clock_out;

  logic [2:0]  enable3 = 3'b000;
  logic        write_enable3 = 1'b0;
  logic [1:0]  write_channel3 = 2'd0;
  logic [7:0]  write_divisor3 = '0;
  logic [2:0]  tick3;
  logic [2:0]  clock_out3;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  clock_divider #(.CHANNELS(2), .WIDTH(32), .DEFAULT_DIVISOR(4)) dut (
    .clock_in      (clk),
    .reset_n       (reset_n),
    .enable        (enable),
    .write_enable  (write_enable),
    .write_channel (write_channel),
    .write_divisor (write_divisor),
    .tick          (tick),
    .clock_out     (clock_out)
  );

  // Three channels leave index 3 unused, so an out-of-range write is expressible.
  clock_divider #(.CHANNELS(3), .WIDTH(8), .DEFAULT_DIVISOR(4)) dut3 (
    .clock_in      (clk),
    .reset_n       (reset_n),
    .enable        (enable3),
    .write_enable  (write_enable3),
    .write_channel (write_channel3),
    .write_divisor (write_divisor3),
    .tick          (tick3),
    .clock_out     (clock_out3)
  );

  typedef struct {
    bit          rst_before;
    logic [1:0]  en;
    logic        we;
    logic        wch;
    logic [31:0] wdiv;
    logic [1:0]  exp_tick;
    logic [1:0]  exp_clk;
  } vec_t;

  vec_t vecs[24];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    // Defaults, divisor 4: ticks at edges 4, 8, 12 on both channels.
    vecs[0]  = '{1'b1, 2'b11, 1'b0, 1'b0, 32'd0, 2'b00, 2'b00};
    vecs[1]  = '{1'b0, 2'b11, 1'b0, 1'b0, 32'd0, 2'b00, 2'b00};
    vecs[2]  = '{1'b0, 2'b11, 1'b0, 1'b0, 32'd0, 2'b00, 2'b00};
    vecs[3]  = '{1'b0, 2'b11, 1'b0, 1'b0, 32'd0, 2'b11, 2'b11};
    vecs[4]  = '{1'b0, 2'b11, 1'b0, 1'b0, 32'd0, 2'b00, 2'b11};
    vecs[5]  = '{1'b0, 2'b11, 1'b0, 1'b0, 32'd0, 2'b00, 2'b11};
    vecs[6]  = '{1'b0, 2'b11, 1'b0, 1'b0, 32'd0, 2'b00, 2'b11};
    vecs[7]  = '{1'b0, 2'b11, 1'b0, 1'b0, 32'd0, 2'b11, 2'b00};
    vecs[8]  = '{1'b0, 2'b11, 1'b0, 1'b0, 32'd0, 2'b00, 2'b00};
    vecs[9]  = '{1'b0, 2'b11, 1'b0, 1'b0, 32'd0, 2'b00, 2'b00};
    vecs[10] = '{1'b0, 2'b11, 1'b0, 1'b0, 32'd0, 2'b00, 2'b00};
    vecs[11] = '{1'b0, 2'b11, 1'b0, 1'b0, 32'd0, 2'b11, 2'b11};
    // Write ch1 divisor 3 at edge 2: ch1 ticks at 5, 8, 11; ch0 unchanged.
    vecs[12] = '{1'b1, 2'b11, 1'b0, 1'b0, 32'd0, 2'b00, 2'b00};
    vecs[13] = '{1'b0, 2'b11, 1'b1, 1'b1, 32'd3, 2'b00, 2'b00};
    vecs[14] = '{1'b0, 2'b11, 1'b0, 1'b0, 32'd0, 2'b00, 2'b00};
    vecs[15] = '{1'b0, 2'b11, 1'b0, 1'b0, 32'd0, 2'b01, 2'b01};
    vecs[16] = '{1'b0, 2'b11, 1'b0, 1'b0, 32'd0, 2'b10, 2'b11};
    vecs[17] = '{1'b0, 2'b11, 1'b0, 1'b0, 32'd0, 2'b00, 2'b11};
    vecs[18] = '{1'b0, 2'b11, 1'b0, 1'b0, 32'd0, 2'b00, 2'b11};
    vecs[19] = '{1'b0, 2'b11, 1'b0, 1'b0, 32'd0, 2'b11, 2'b00};
    vecs[20] = '{1'b0, 2'b11, 1'b0, 1'b0, 32'd0, 2'b00, 2'b00};
    vecs[21] = '{1'b0, 2'b11, 1'b0, 1'b0, 32'd0, 2'b00, 2'b00};
    vecs[22] = '{1'b0, 2'b11, 1'b0, 1'b0, 32'd0, 2'b10, 2'b10};
    vecs[23] = '{1'b0, 2'b11, 1'b0, 1'b0, 32'd0, 2'b01, 2'b11};

    #1;
    check("reset_tick", {30'd0, tick}, 32'd0);
    check("reset_clock_out", {30'd0, clock_out}, 32'd0);

    for (int i = 0; i < 24; i++) begin
      if (vecs[i].rst_before) do_reset();
      enable        = vecs[i].en;
      write_enable  = vecs[i].we;
      write_channel = vecs[i].wch;
      write_divisor = vecs[i].wdiv;
      step();
      write_enable = 1'b0;
      check($sformatf("vec%0d_tick", i), {30'd0, tick}, {30'd0, vecs[i].exp_tick});
      check($sformatf("vec%0d_clock_out", i), {30'd0, clock_out}, {30'd0, vecs[i].exp_clk});
    end

    // Divisor 0, then divisor 1: tick constant, clock_out toggles every edge.
    begin
      logic exp_c;
      do_reset();
      enable = 2'b11;
      write_enable = 1'b1; write_channel = 1'b0; write_divisor = 32'd0;
      step();
      write_enable = 1'b0;
      check("div0_write_tick", {31'd0, tick[0]}, 32'd0);
      exp_c = 1'b0;
      for (int i = 0; i < 6; i++) begin
        step();
        exp_c = ~exp_c;
        check("div0_tick", {31'd0, tick[0]}, 32'd1);
        check("div0_clock_out", {31'd0, clock_out[0]}, {31'd0, exp_c});
      end
      write_enable = 1'b1; write_divisor = 32'd1;
      step();
      write_enable = 1'b0;
      check("div1_write_tick", {31'd0, tick[0]}, 32'd0);
      check("div1_write_hold", {31'd0, clock_out[0]}, {31'd0, exp_c});
      for (int i = 0; i < 4; i++) begin
        step();
        exp_c = ~exp_c;
        check("div1_tick", {31'd0, tick[0]}, 32'd1);
        check("div1_clock_out", {31'd0, clock_out[0]}, {31'd0, exp_c});
      end
    end

    // Enable freeze: divisor 5, freeze at C=3 for 10 cycles, tick 2 edges after resume.
    do_reset();
    enable = 2'b11;
    write_enable = 1'b1; write_channel = 1'b0; write_divisor = 32'd5;
    step();
    write_enable = 1'b0;
    repeat (3) begin
      step();
      check("freeze_pre_tick", {31'd0, tick[0]}, 32'd0);
    end
    enable = 2'b10;
    for (int i = 0; i < 10; i++) begin
      step();
      check("freeze_tick", {31'd0, tick[0]}, 32'd0);
      check("freeze_clock_out", {31'd0, clock_out[0]}, 32'd0);
    end
    enable = 2'b11;
    step();
    check("resume1_tick", {31'd0, tick[0]}, 32'd0);
    step();
    check("resume2_tick", {31'd0, tick[0]}, 32'd1);
    check("resume2_clock_out", {31'd0, clock_out[0]}, 32'd1);

    // Write collides with terminal count on ch0; ch1 ticks normally.
    do_reset();
    enable = 2'b11;
    repeat (3) step();
    write_enable = 1'b1; write_channel = 1'b0; write_divisor = 32'd4;
    step();
    write_enable = 1'b0;
    check("collide_tick", {30'd0, tick}, 32'b10);
    check("collide_clock_out", {30'd0, clock_out}, 32'b10);
    repeat (3) begin
      step();
      check("collide_after_tick", {31'd0, tick[0]}, 32'd0);
    end
    step();
    check("collide_next_tick", {31'd0, tick[0]}, 32'd1);

    // Out-of-range write on a 3-channel instance changes nothing.
    do_reset();
    enable3 = 3'b111;
    step();
    write_enable3 = 1'b1; write_channel3 = 2'd3; write_divisor3 = 8'd7;
    step();
    write_enable3 = 1'b0;
    step();
    check("badidx_e3_tick", {29'd0, tick3}, 32'd0);
    step();
    check("badidx_e4_tick", {29'd0, tick3}, 32'b111);
    check("badidx_e4_clock_out", {29'd0, clock_out3}, 32'b111);
    repeat (3) step();
    step();
    check("badidx_e8_tick", {29'd0, tick3}, 32'b111);
    enable3 = 3'b000;

    // Asynchronous reset mid-period clears outputs and forgets the divisor.
    do_reset();
    enable = 2'b11;
    write_enable = 1'b1; write_channel = 1'b0; write_divisor = 32'd2;
    step();
    write_enable = 1'b0;
    step();
    step();
    check("areset_pre_tick", {31'd0, tick[0]}, 32'd1);
    check("areset_pre_clock_out", {31'd0, clock_out[0]}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("areset_tick", {30'd0, tick}, 32'd0);
    check("areset_clock_out", {30'd0, clock_out}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    step();
    step();
    check("areset_div_e2_tick", {31'd0, tick[0]}, 32'd0);
    step();
    step();
    check("areset_div_e4_tick", {31'd0, tick[0]}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_clock_divider
`default_nettype wire
